// File: rtl/upc_checkout_tally.sv
// upc_checkout_tally: turns debounced scan / clear key presses into BCD item
// and discount tallies, and latches a blinking theft alarm when a stolen item
// is scanned until the clear key is pressed.
module upc_checkout_tally #(
  parameter int BLINK_DIV = 25_000_000,
  parameter int CNT_MAX   = 99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scan_n,
  input  logic       clear_n,
  input  logic       stolen,
  input  logic       discount,
  output logic [7:0] item_bcd,
  output logic [7:0] disc_bcd,
  output logic       alarm,
  output logic       alarm_blink,
  output logic       scan_ack
);

  localparam int             DIV_W    = $clog2(BLINK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);
  // Saturation value expressed as {tens,ones} BCD so it compares directly
  localparam logic [7:0]     MAX_BCD  = {4'(CNT_MAX / 10), 4'(CNT_MAX % 10)};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ALARM = 1'b1
  } state_t;

  state_t           state_r;
  logic [DIV_W-1:0] div_r;

  logic scan_sync1_r, scan_sync2_r, scan_prev_r;
  logic clear_sync1_r, clear_sync2_r, clear_prev_r;
  logic scan_pulse_s, clear_pulse_s;

  // Saturating two-digit BCD increment: ones 9 carries into tens, holds at max
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == MAX_BCD) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Two-flop synchronizers plus a previous-value flop per key; idle level is 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_sync1_r  <= 1'b1;
      scan_sync2_r  <= 1'b1;
      scan_prev_r   <= 1'b1;
      clear_sync1_r <= 1'b1;
      clear_sync2_r <= 1'b1;
      clear_prev_r  <= 1'b1;
    end else begin
      scan_sync1_r  <= scan_n;
      scan_sync2_r  <= scan_sync1_r;
      scan_prev_r   <= scan_sync2_r;
      clear_sync1_r <= clear_n;
      clear_sync2_r <= clear_sync1_r;
      clear_prev_r  <= clear_sync2_r;
    end
  end

  // One-cycle press pulse on each synchronized falling edge (held key = one pulse)
  always_comb begin
    scan_pulse_s  = scan_prev_r & ~scan_sync2_r;
    clear_pulse_s = clear_prev_r & ~clear_sync2_r;
  end

  // Control FSM with registered tallies, alarm, blink divider and scan ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      div_r       <= '0;
      item_bcd    <= 8'h00;
      disc_bcd    <= 8'h00;
      alarm       <= 1'b0;
      alarm_blink <= 1'b0;
      scan_ack    <= 1'b0;
    end else begin
      scan_ack <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          alarm       <= 1'b0;
          alarm_blink <= 1'b0;
          div_r       <= '0;
          if (scan_pulse_s) begin
            if (stolen) begin
              // Blink starts in its "on" phase with a fresh divider
              state_r     <= ST_ALARM;
              alarm       <= 1'b1;
              alarm_blink <= 1'b1;
            end else begin
              item_bcd <= bcd_inc(item_bcd);
              if (discount) begin
                disc_bcd <= bcd_inc(disc_bcd);
              end else begin
                disc_bcd <= disc_bcd;
              end
              scan_ack <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ALARM: begin
          // Scan presses are ignored here; clear takes priority over everything
          if (clear_pulse_s) begin
            state_r     <= ST_IDLE;
            alarm       <= 1'b0;
            alarm_blink <= 1'b0;
            div_r       <= '0;
          end else if (div_r == DIV_LAST) begin
            div_r       <= '0;
            alarm_blink <= ~alarm_blink;
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          alarm       <= 1'b0;
          alarm_blink <= 1'b0;
          div_r       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upc_checkout_tally.sv
// Self-checking bench for upc_checkout_tally: a scoreboard queue holds the
// expected tallies for each accepted scan and is popped on every scan_ack.
module tb_upc_checkout_tally;

  logic       clk;
  logic       reset_n;
  logic       scan_n;
  logic       clear_n;
  logic       stolen;
  logic       discount;
  logic [7:0] item_bcd;
  logic [7:0] disc_bcd;
  logic       alarm;
  logic       alarm_blink;
  logic       scan_ack;

  typedef struct packed {
    logic [7:0] item;
    logic [7:0] disc;
  } entry_t;

  entry_t sb_q[$];
  entry_t mon_e;
  int     n_checks = 0;
  int     n_fail   = 0;
  int     ack_cnt  = 0;
  int     item_m   = 0;
  int     disc_m   = 0;

  upc_checkout_tally #(
    .BLINK_DIV(4),
    .CNT_MAX  (99)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .scan_n     (scan_n),
    .clear_n    (clear_n),
    .stolen     (stolen),
    .discount   (discount),
    .item_bcd   (item_bcd),
    .disc_bcd   (disc_bcd),
    .alarm      (alarm),
    .alarm_blink(alarm_blink),
    .scan_ack   (scan_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // Model an accepted scan and queue the tallies the DUT should show with its ack
  task automatic expect_accept(input logic dc);
    if (item_m < 99) item_m = item_m + 1;
    if (dc && disc_m < 99) disc_m = disc_m + 1;
    sb_q.push_back({to_bcd(item_m), to_bcd(disc_m)});
  endtask

  // Scoreboard monitor: every scan_ack must match the oldest queued expectation
  always @(negedge clk) begin
    if (reset_n && scan_ack) begin
      ack_cnt  = ack_cnt + 1;
      n_checks = n_checks + 1;
      if (sb_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_ack: scan_ack=1 item_bcd=%h, required no ack", item_bcd);
      end else begin
        mon_e = sb_q.pop_front();
        if ({item_bcd, disc_bcd} !== {mon_e.item, mon_e.disc}) begin
          n_fail = n_fail + 1;
          $display("FAIL sb_tally: item/disc=%h/%h, required %h/%h",
                   item_bcd, disc_bcd, mon_e.item, mon_e.disc);
        end
      end
    end
  end

  task automatic do_reset();
    reset_n  = 1'b0;
    scan_n   = 1'b1;
    clear_n  = 1'b1;
    stolen   = 1'b0;
    discount = 1'b0;
    item_m   = 0;
    disc_m   = 0;
    sb_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic press_scan(input logic st, input logic dc, input int hold);
    stolen   = st;
    discount = dc;
    @(negedge clk);
    scan_n = 1'b0;
    repeat (hold) @(negedge clk);
    scan_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_counts(input string name);
    n_checks = n_checks + 1;
    if ({item_bcd, disc_bcd} !== {to_bcd(item_m), to_bcd(disc_m)}) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: item/disc=%h/%h, required %h/%h", name,
               item_bcd, disc_bcd, to_bcd(item_m), to_bcd(disc_m));
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    scan_n  = 1'b1;
    clear_n = 1'b1;
    stolen  = 1'b0;
    discount = 1'b0;
    #2;
    n_checks = n_checks + 1;
    if ({item_bcd, disc_bcd, alarm, alarm_blink, scan_ack} !== 19'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_outputs: %h %h %b %b %b, required all zero",
               item_bcd, disc_bcd, alarm, alarm_blink, scan_ack);
    end
    do_reset();
    check_counts("reset_counts");
  endtask

  task automatic test_basic();
    stolen   = 1'b0;
    discount = 1'b0;
    @(negedge clk);
    scan_n = 1'b0;
    expect_accept(1'b0);
    repeat (2) @(negedge clk);
    n_checks = n_checks + 1;
    if (scan_ack !== 1'b0 || item_bcd !== 8'h00) begin
      n_fail = n_fail + 1;
      $display("FAIL basic_early: ack=%b item=%h, required 0/00", scan_ack, item_bcd);
    end
    @(negedge clk);
    n_checks = n_checks + 1;
    if (scan_ack !== 1'b1 || item_bcd !== 8'h01 || disc_bcd !== 8'h00) begin
      n_fail = n_fail + 1;
      $display("FAIL basic_third_edge: ack=%b item=%h disc=%h, required 1/01/00",
               scan_ack, item_bcd, disc_bcd);
    end
    @(negedge clk);
    n_checks = n_checks + 1;
    if (scan_ack !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL basic_ack_width: ack=%b, required 0", scan_ack);
    end
    scan_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_discount();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      expect_accept(1'b1);
      press_scan(1'b0, 1'b1, 3);
    end
    n_checks = n_checks + 1;
    if (item_bcd !== 8'h12 || disc_bcd !== 8'h12) begin
      n_fail = n_fail + 1;
      $display("FAIL discount_x12: item=%h disc=%h, required 12/12", item_bcd, disc_bcd);
    end
  endtask

  task automatic test_hold();
    int acks_before;
    acks_before = ack_cnt;
    expect_accept(1'b0);
    press_scan(1'b0, 1'b0, 100);
    n_checks = n_checks + 1;
    if (ack_cnt - acks_before !== 1) begin
      n_fail = n_fail + 1;
      $display("FAIL hold_one_ack: acks=%0d, required 1", ack_cnt - acks_before);
    end
    check_counts("hold_counts");
  endtask

  task automatic test_alarm();
    logic [7:0] pat;
    int         acks_before;
    pat         = 8'b1111_0000;
    acks_before = ack_cnt;
    stolen      = 1'b1;
    discount    = 1'b1;
    @(negedge clk);
    scan_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks = n_checks + 1;
    if (alarm !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL alarm_early: alarm=%b, required 0", alarm);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      n_checks = n_checks + 1;
      if (alarm !== 1'b1 || alarm_blink !== pat[7-i]) begin
        n_fail = n_fail + 1;
        $display("FAIL blink_seq[%0d]: alarm=%b blink=%b, required 1/%b",
                 i, alarm, alarm_blink, pat[7-i]);
      end
      if (i == 0) scan_n = 1'b1;
      @(negedge clk);
    end
    check_counts("alarm_counts");
    press_scan(1'b0, 1'b1, 3);
    n_checks = n_checks + 1;
    if (alarm !== 1'b1 || ack_cnt !== acks_before) begin
      n_fail = n_fail + 1;
      $display("FAIL alarm_ignore_scan: alarm=%b acks=%0d, required 1/%0d",
               alarm, ack_cnt, acks_before);
    end
    check_counts("alarm_ignored_counts");
    @(negedge clk);
    clear_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks = n_checks + 1;
    if (alarm !== 1'b0 || alarm_blink !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL alarm_clear: alarm=%b blink=%b, required 0/0", alarm, alarm_blink);
    end
    clear_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 105; i++) begin
      expect_accept(logic'(i % 2));
      press_scan(1'b0, logic'(i % 2), 3);
    end
    n_checks = n_checks + 1;
    if (item_bcd !== 8'h99) begin
      n_fail = n_fail + 1;
      $display("FAIL saturate_item: item=%h, required 99", item_bcd);
    end
    check_counts("saturate_counts");
  endtask

  task automatic test_clear_wins();
    int acks_before;
    do_reset();
    expect_accept(1'b1);
    press_scan(1'b0, 1'b1, 3);
    press_scan(1'b1, 1'b0, 3);
    acks_before = ack_cnt;
    stolen = 1'b0;
    @(negedge clk);
    scan_n  = 1'b0;
    clear_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks = n_checks + 1;
    if (alarm !== 1'b0 || alarm_blink !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL clear_wins_state: alarm=%b blink=%b, required 0/0", alarm, alarm_blink);
    end
    scan_n  = 1'b1;
    clear_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks = n_checks + 1;
    if (ack_cnt !== acks_before) begin
      n_fail = n_fail + 1;
      $display("FAIL clear_wins_ack: acks=%0d, required %0d", ack_cnt, acks_before);
    end
    check_counts("clear_wins_counts");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      expect_accept(1'b1);
      press_scan(1'b0, 1'b1, 3);
    end
    check_counts("pre_async_counts");
    press_scan(1'b1, 1'b0, 3);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks = n_checks + 1;
    if ({item_bcd, disc_bcd, alarm, alarm_blink, scan_ack} !== 19'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL async_reset: %h %h %b %b %b, required all zero",
               item_bcd, disc_bcd, alarm, alarm_blink, scan_ack);
    end
    do_reset();
    check_counts("post_async_counts");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_discount();
    test_hold();
    test_alarm();
    test_saturate();
    test_clear_wins();
    test_async_reset();
    n_checks = n_checks + 1;
    if (sb_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL sb_drained: %0d entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
